// File: rtl/audio_sample_packet_receiver_if.sv
// Packet-in / sample-out bus of the HDMI audio sample packet receiver.
// The master side presents decoded data-island packets and consumes samples.
// The slave side (the receiver) unpacks the packets and produces samples.
interface audio_sample_packet_receiver_if;
    logic             packet_valid;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic             sample_valid;
    logic             sample_ready;
    logic [23:0]      sample_left;
    logic [23:0]      sample_right;
    logic [1:0]       sample_valid_bits;
    logic             sample_block_start;

    modport master (
        output packet_valid, header, sub, sample_ready,
        input  sample_valid, sample_left, sample_right, sample_valid_bits, sample_block_start
    );

    modport slave (
        input  packet_valid, header, sub, sample_ready,
        output sample_valid, sample_left, sample_right, sample_valid_bits, sample_block_start
    );
endinterface

// File: rtl/audio_sample_packet_receiver.sv
// HDMI Audio Sample Packet receiver (type 0x02, 2-channel layout).
// Unpacks present subpackets into a show-ahead sample FIFO, tracks the
// 192-frame IEC 60958 channel-status block using the B flags, and
// publishes the first CS_BITS channel-status bits of each channel.
// Optional feature: define AUDIO_SAMPLE_PACKET_RECEIVER_PARITY_CHECK_EN to drop
// samples failing parity and count them in parity_error_count.
module audio_sample_packet_receiver #(
    parameter int FIFO_DEPTH = 8,
    parameter int CS_BITS    = 40
) (
    input  logic                         clk_pixel,
    input  logic                         reset_n,
    audio_sample_packet_receiver_if.slave bus,
    output logic [CS_BITS-1:0]           channel_status_left,
    output logic [CS_BITS-1:0]           channel_status_right,
    output logic                         channel_status_update,
    output logic                         block_sync,
    output logic                         sync_error,
    output logic [15:0]                  parity_error_count,
    output logic                         overflow
);
    localparam int              PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [7:0]      LAST_POS   = 8'd191;

    typedef enum logic {IDLE, UNPACK} state_t;

    typedef struct packed {
        logic        block_start;
        logic [1:0]  v;
        logic [23:0] right;
        logic [23:0] left;
    } entry_t;

    state_t           state;
    logic [3:0]       pending;
    logic [3:0]       hold_b;
    logic [3:0][55:0] hold_sub;

    entry_t           mem [FIFO_DEPTH];
    entry_t           head_q;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;

    logic [CS_BITS-1:0] acc_left, acc_right;
    logic [7:0]         pos;

    // Packet acceptance and current-subpacket selection.
    logic       accept, processing;
    logic [1:0] idx;
    logic [3:0] idx_mask;
    logic [55:0] cur_sub;
    logic       cur_b;
    entry_t     wr_entry;
    logic       unused_header_bits;

    assign accept     = bus.packet_valid && (bus.header[7:0] == 8'h02) && !bus.header[12];
    assign processing = (state == UNPACK);
    assign unused_header_bits = ^bus.header[19:13];

    // Lowest-numbered subpacket still waiting is processed this cycle.
    // NOTE: combinational blocks assign every output a default first so no path can infer a latch.
    always_comb begin
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) idx = 2'(i);
        end
    end

    assign idx_mask = 4'b0001 << idx;
    assign cur_sub  = hold_sub[idx];
    assign cur_b    = hold_b[idx];
    assign wr_entry = '{block_start: cur_b,
                        v:           {cur_sub[52], cur_sub[48]},
                        right:       cur_sub[47:24],
                        left:        cur_sub[23:0]};

    logic parity_bad;
`ifdef AUDIO_SAMPLE_PACKET_RECEIVER_PARITY_CHECK_EN
    assign parity_bad = (^{cur_sub[51:48], cur_sub[23:0]}) | (^{cur_sub[55:52], cur_sub[47:24]});
`else
    logic unused_parity_bits;
    assign parity_bad         = 1'b0;
    assign unused_parity_bits = ^{cur_sub[55], cur_sub[53], cur_sub[51], cur_sub[49]};
`endif

    // FIFO bookkeeping: full check ignores a same-cycle pop.
    logic           wr_req, wr_en, drop, pop, head_load;
    logic [PTR_W:0] count_after_pop, count_next;
    logic [PTR_W-1:0] rd_ptr_next;
    entry_t         head_next;

    assign wr_req          = processing && !parity_bad;
    assign wr_en           = wr_req && (count != FULL_COUNT);
    assign drop            = wr_req && (count == FULL_COUNT);
    assign pop             = bus.sample_valid && bus.sample_ready;
    assign count_after_pop = count - (PTR_W+1)'(pop);
    assign count_next      = count_after_pop + (PTR_W+1)'(wr_en);
    assign rd_ptr_next     = rd_ptr + PTR_W'(pop);
    assign head_load       = (pop || (count == '0)) && (count_next != '0);
    assign head_next       = (count_after_pop == '0) ? wr_entry : mem[rd_ptr_next];

    assign bus.sample_left        = head_q.left;
    assign bus.sample_right       = head_q.right;
    assign bus.sample_valid_bits  = head_q.v;
    assign bus.sample_block_start = head_q.block_start;

    // Unpack FSM: latch an accepted packet, then walk its present subpackets.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pending  <= 4'd0;
            hold_b   <= 4'd0;
            hold_sub <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (bus.header[11:8] != 4'd0)) begin
                        pending  <= bus.header[11:8];
                        hold_b   <= bus.header[23:20];
                        hold_sub <= bus.sub;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    pending <= pending & ~idx_mask;
                    if ((pending & ~idx_mask) == 4'd0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sample storage array.
    // NOTE: the storage array has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge clk_pixel) begin
        if (wr_en) mem[wr_ptr] <= wr_entry;
    end

    // FIFO pointers, registered show-ahead head and sticky overflow.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            count            <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            head_q           <= '0;
            bus.sample_valid <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            count            <= count_next;
            rd_ptr           <= rd_ptr_next;
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (head_load) head_q <= head_next;
            bus.sample_valid <= (count_next != '0);
            if (drop || (accept && processing)) overflow <= 1'b1;
        end
    end

    // Channel-status block tracking for the sample processed this cycle.
    logic [CS_BITS-1:0] acc_left_next, acc_right_next;
    logic [7:0]         pos_next;
    logic               sync_next, sync_err_next, publish;

    always_comb begin
        acc_left_next  = acc_left;
        acc_right_next = acc_right;
        pos_next       = pos;
        sync_next      = block_sync;
        sync_err_next  = 1'b0;
        publish        = 1'b0;
        if (processing) begin
            if (cur_b) begin
                acc_left_next     = '0;
                acc_right_next    = '0;
                acc_left_next[0]  = cur_sub[50];
                acc_right_next[0] = cur_sub[54];
                pos_next          = 8'd1;
                sync_next         = 1'b1;
                sync_err_next     = block_sync && (pos != 8'd0);
            end else if (block_sync && (pos != 8'd0)) begin
                for (int k = 0; k < CS_BITS; k++) begin
                    if (pos == 8'(k)) begin
                        acc_left_next[k]  = cur_sub[50];
                        acc_right_next[k] = cur_sub[54];
                    end
                end
                if (pos == LAST_POS) begin
                    publish  = 1'b1;
                    pos_next = 8'd0;
                end else begin
                    pos_next = pos + 8'd1;
                end
            end else begin
                sync_next = 1'b0;
            end
        end
    end

    // Register block position, accumulators and the published status words.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            acc_left              <= '0;
            acc_right             <= '0;
            pos                   <= 8'd0;
            block_sync            <= 1'b0;
            sync_error            <= 1'b0;
            channel_status_left   <= '0;
            channel_status_right  <= '0;
            channel_status_update <= 1'b0;
        end else begin
            acc_left              <= acc_left_next;
            acc_right             <= acc_right_next;
            pos                   <= pos_next;
            block_sync            <= sync_next;
            sync_error            <= sync_err_next;
            channel_status_update <= publish;
            if (publish) begin
                channel_status_left  <= acc_left_next;
                channel_status_right <= acc_right_next;
            end
        end
    end

`ifdef AUDIO_SAMPLE_PACKET_RECEIVER_PARITY_CHECK_EN
    // Saturating count of samples rejected for parity.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            parity_error_count <= 16'd0;
        end else if (processing && parity_bad && (parity_error_count != 16'hFFFF)) begin
            parity_error_count <= parity_error_count + 16'd1;
        end
    end
`else
    assign parity_error_count = 16'd0;
`endif
endmodule
